esp32_prog_sequencer: RTL and testbench

- Owns the ESP32 EN/GPIO0 straps and the ESP32 UART.
- Arbitrates the UART between the FTDI host (esptool programming) and the FPGA's internal UART.
- Decodes synchronized DTR/RTS into timed reset and boot-entry sequences with guaranteed minimum pulse widths.
- Returns UART ownership to the FPGA after an idle timeout. Sits between the top-level pins and the FPGA's UART core.

---
 rtl/esp32_prog_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/esp32_prog_sequencer.sv | 166 ++++++++++++++++
 tb/tb_esp32_prog_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/esp32_prog_pkg.sv
// rtl/esp32_prog_pkg.sv - shared states, strap patterns and default timing for the ESP32 sequencer
package esp32_prog_pkg;

    typedef enum logic [1:0] {
        FPGA_OWN,
        RESET_HOLD,
        BOOT_ENTRY,
        PASSTHRU
    } state_t;

    // {sync_ndtr, sync_nrts}; the FTDI lines are active-low
    localparam logic [1:0] PAT_RESET = 2'b10;
    localparam logic [1:0] PAT_BOOT  = 2'b01;
    localparam logic [1:0] PAT_IDLE  = 2'b11;

    localparam int DEF_EN_LOW_CYCLES       = 2500;
    localparam int DEF_GPIO0_HOLD_CYCLES   = 25000;
    localparam int DEF_IDLE_TIMEOUT_CYCLES = 250000000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer bank with a configurable reset value
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= RESET_VAL;
            r_q    <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/esp32_prog_sequencer.sv
// rtl/esp32_prog_sequencer.sv - ESP32 strap/reset sequencer and UART arbiter between FTDI host and FPGA
module esp32_prog_sequencer
    import esp32_prog_pkg::*;
#(
    parameter int EN_LOW_CYCLES       = DEF_EN_LOW_CYCLES,
    parameter int GPIO0_HOLD_CYCLES   = DEF_GPIO0_HOLD_CYCLES,
    parameter int IDLE_TIMEOUT_CYCLES = DEF_IDLE_TIMEOUT_CYCLES
) (
    input  logic clk_25mhz,
    input  logic reset,
    input  logic ftdi_ndtr,
    input  logic ftdi_nrts,
    input  logic ftdi_txd,
    output logic ftdi_rxd,
    input  logic wifi_txd,
    output logic wifi_rxd,
    output logic wifi_en,
    output logic wifi_gpio0,
    input  logic fpga_uart_tx,
    output logic fpga_uart_rx,
    input  logic fpga_esp_reset_req,
    output logic passthru_active
);

    localparam int CNT_MAX = max3(EN_LOW_CYCLES, GPIO0_HOLD_CYCLES, IDLE_TIMEOUT_CYCLES);
    localparam int CW      = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] EN_LAST   = CW'(EN_LOW_CYCLES - 1);
    localparam logic [CW-1:0] GPIO_LAST = CW'(GPIO0_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT   = '1;

    logic [3:0] w_sync;
    logic [1:0] w_pat;
    logic       w_ftxd;
    logic       w_wtxd;

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL ({PAT_IDLE, 2'b11})
    ) u_sync (
        .i_clk   (clk_25mhz),
        .i_reset (reset),
        .i_d     ({ftdi_ndtr, ftdi_nrts, ftdi_txd, wifi_txd}),
        .o_q     (w_sync)
    );

    assign w_pat  = w_sync[3:2];
    assign w_ftxd = w_sync[1];
    assign w_wtxd = w_sync[0];

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_boot, w_boot;
    logic          r_ftxd_d, r_wtxd_d;
    logic          w_clr;
    logic          w_activity;
    logic          w_en, w_gpio0, w_wrxd, w_frxd, w_urx, w_pa;

    // Start bits in either direction keep the host session alive
    assign w_activity = (r_ftxd_d & ~w_ftxd) | (r_wtxd_d & ~w_wtxd);

    always_comb begin
        w_next = r_state;
        w_boot = r_boot;
        w_clr  = 1'b0;
        case (r_state)
            FPGA_OWN: begin
                if (w_pat == PAT_RESET || fpga_esp_reset_req)
                    w_next = RESET_HOLD;
            end
            RESET_HOLD: begin
                if (w_pat == PAT_RESET) begin
                    w_boot = 1'b0;
                    w_clr  = 1'b1;
                end else begin
                    if (w_pat == PAT_BOOT)
                        w_boot = 1'b1;
                    if (r_cnt >= EN_LAST)
                        w_next = (r_boot || w_pat == PAT_BOOT) ? BOOT_ENTRY : FPGA_OWN;
                end
            end
            BOOT_ENTRY: begin
                if (w_pat == PAT_RESET)
                    w_next = RESET_HOLD;
                else if (r_cnt >= GPIO_LAST && w_pat != PAT_BOOT)
                    w_next = PASSTHRU;
            end
            PASSTHRU: begin
                if (w_pat == PAT_RESET)
                    w_next = RESET_HOLD;
                else if (w_activity)
                    w_clr = 1'b1;
                else if (r_cnt >= IDLE_LAST)
                    w_next = FPGA_OWN;
            end
            default: w_next = RESET_HOLD;
        endcase

        // boot_flag only carries meaning while EN is held low
        if (w_next != RESET_HOLD || r_state != RESET_HOLD)
            w_boot = (w_next == RESET_HOLD && r_state == RESET_HOLD) ? w_boot : 1'b0;

        if (w_next != r_state || w_clr)
            w_cnt = '0;
        else if (r_cnt != CNT_SAT)
            w_cnt = r_cnt + 1'b1;
        else
            w_cnt = r_cnt;

        w_en    = 1'b1;
        w_gpio0 = 1'b1;
        w_wrxd  = 1'b1;
        w_frxd  = 1'b1;
        w_urx   = 1'b1;
        w_pa    = 1'b0;
        case (w_next)
            FPGA_OWN: begin
                w_wrxd = fpga_uart_tx;
                w_urx  = w_wtxd;
            end
            RESET_HOLD: w_en = 1'b0;
            BOOT_ENTRY: begin
                w_gpio0 = 1'b0;
                w_pa    = 1'b1;
                w_wrxd  = w_ftxd;
                w_frxd  = w_wtxd;
            end
            PASSTHRU: begin
                w_pa   = 1'b1;
                w_wrxd = w_ftxd;
                w_frxd = w_wtxd;
            end
            default: w_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            r_state         <= RESET_HOLD;
            r_cnt           <= '0;
            r_boot          <= 1'b0;
            r_ftxd_d        <= 1'b1;
            r_wtxd_d        <= 1'b1;
            wifi_en         <= 1'b0;
            wifi_gpio0      <= 1'b1;
            wifi_rxd        <= 1'b1;
            ftdi_rxd        <= 1'b1;
            fpga_uart_rx    <= 1'b1;
            passthru_active <= 1'b0;
        end else begin
            r_state         <= w_next;
            r_cnt           <= w_cnt;
            r_boot          <= w_boot;
            r_ftxd_d        <= w_ftxd;
            r_wtxd_d        <= w_wtxd;
            wifi_en         <= w_en;
            wifi_gpio0      <= w_gpio0;
            wifi_rxd        <= w_wrxd;
            ftdi_rxd        <= w_frxd;
            fpga_uart_rx    <= w_urx;
            passthru_active <= w_pa;
        end
    end

endmodule

// File: tb/tb_esp32_prog_sequencer.sv
// tb/tb_esp32_prog_sequencer.sv - scoreboard bench for esp32_prog_sequencer
module tb_esp32_prog_sequencer;

    // {wifi_en, wifi_gpio0, passthru_active, wifi_rxd, ftdi_rxd, fpga_uart_rx}
    localparam logic [5:0] V_RST  = 6'b010111;
    localparam logic [5:0] V_OWN  = 6'b110111;
    localparam logic [5:0] V_BOOT = 6'b101111;
    localparam logic [5:0] V_PT   = 6'b111111;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ndtr = 1'b1, nrts = 1'b1, ftxd = 1'b1, wtxd = 1'b1, utx = 1'b1, req = 1'b0;
    logic frxd, wrxd, en, g0, urx, pa;
    logic [5:0] obs;
    logic [5:0] prev = 6'b000000;
    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int         at;
        logic [5:0] v;
    } exp_t;
    exp_t q[$];
    exp_t e_cur;

    esp32_prog_sequencer #(
        .EN_LOW_CYCLES       (4),
        .GPIO0_HOLD_CYCLES   (8),
        .IDLE_TIMEOUT_CYCLES (50)
    ) dut (
        .clk_25mhz          (clk),
        .reset              (reset),
        .ftdi_ndtr          (ndtr),
        .ftdi_nrts          (nrts),
        .ftdi_txd           (ftxd),
        .ftdi_rxd           (frxd),
        .wifi_txd           (wtxd),
        .wifi_rxd           (wrxd),
        .wifi_en            (en),
        .wifi_gpio0         (g0),
        .fpga_uart_tx       (utx),
        .fpga_uart_rx       (urx),
        .fpga_esp_reset_req (req),
        .passthru_active    (pa)
    );

    assign obs = {en, g0, pa, wrxd, frxd, urx};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Checks on every output change and at every scheduled checkpoint cycle
    always @(negedge clk) begin
        if (obs != prev || (q.size() > 0 && q[0].at == cyc)) begin
            n_vec++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change cyc=%0d got=%b", cyc, obs);
            end else begin
                e_cur = q.pop_front();
                if (e_cur.at != cyc || obs != e_cur.v) begin
                    n_bad++;
                    $display("FAIL event@%0d got=%b at cyc %0d, want=%b at cyc %0d",
                             e_cur.at, obs, cyc, e_cur.v, e_cur.at);
                end
            end
        end
        prev = obs;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic ex(input int at, input logic [5:0] v);
        exp_t t;
        t.at = at;
        t.v  = v;
        q.push_back(t);
    endtask

    // Host esptool: RTS pulse 2 cycles, DTR 3 cycles, then idle
    task automatic esptool(output int base);
        base = cyc;
        {ndtr, nrts} = 2'b10;
        ex(base + 3, V_RST);
        step(2);
        {ndtr, nrts} = 2'b01;
        step(3);
        {ndtr, nrts} = 2'b11;
        ex(base + 7, V_RST);
        ex(base + 8, V_BOOT);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int b;
        logic [4:0] tx_pat;
        tx_pat = 5'b10110;

        ex(1, V_RST);
        step(3);
        n = cyc;
        reset = 1'b0;
        ex(n + 3, V_RST);
        ex(n + 4, V_OWN);
        step(6);

        for (int i = 0; i < 5; i++) begin
            n = cyc;
            utx = tx_pat[i];
            ex(n + 1, {3'b110, tx_pat[i], 2'b11});
            step(1);
        end
        n = cyc;
        wtxd = 1'b0;
        ex(n + 3, 6'b110110);
        step(2);
        wtxd = 1'b1;
        ex(n + 5, V_OWN);
        step(6);

        esptool(b);
        ex(b + 15, V_BOOT);
        ex(b + 16, V_PT);
        step(13);
        n = cyc;
        ftxd = 1'b0;
        ex(n + 3, 6'b111011);
        step(1);
        ftxd = 1'b1;
        ex(n + 4, V_PT);
        step(5);
        n = cyc;
        wtxd = 1'b0;
        ex(n + 3, 6'b111101);
        step(1);
        wtxd = 1'b1;
        ex(n + 4, V_PT);

        // 2 sync stages + edge detect put the counter restart 3 cycles after the pin edge
        for (int k = 0; k < 6; k++) begin
            step(k == 0 ? 10 : 39);
            n = cyc;
            ftxd = 1'b0;
            ex(n + 3, 6'b111011);
            step(1);
            ftxd = 1'b1;
            ex(n + 4, V_PT);
        end
        ex(n + 52, V_PT);
        ex(n + 53, V_OWN);
        step(60);
        n = cyc;
        wtxd = 1'b0;
        ex(n + 3, 6'b110110);
        step(1);
        wtxd = 1'b1;
        ex(n + 4, V_OWN);
        step(5);

        n = cyc;
        req = 1'b1;
        ex(n + 1, V_RST);
        ex(n + 4, V_RST);
        ex(n + 5, V_OWN);
        step(1);
        req = 1'b0;
        step(8);

        esptool(b);
        step(3);
        {ndtr, nrts} = 2'b10;
        ex(b + 11, V_RST);
        step(2);
        {ndtr, nrts} = 2'b11;
        ex(b + 15, V_RST);
        ex(b + 16, V_OWN);
        step(10);

        esptool(b);
        ex(b + 15, V_BOOT);
        ex(b + 16, V_PT);
        step(13);
        n = cyc;
        req = 1'b1;
        ex(n + 2, V_PT);
        step(1);
        req = 1'b0;
        step(3);
        n = cyc;
        {ndtr, nrts} = 2'b10;
        ex(n + 3, V_RST);
        ex(n + 25, V_RST);
        ex(n + 26, V_OWN);
        step(20);
        {ndtr, nrts} = 2'b11;
        step(10);

        esptool(b);
        step(5);
        n = cyc;
        reset = 1'b1;
        ex(n + 1, V_RST);
        step(2);
        reset = 1'b0;
        ex(n + 5, V_RST);
        ex(n + 6, V_OWN);
        step(10);

        for (int i = 0; i < 100 && q.size() > 0; i++) step(1);
        while (q.size() > 0) begin
            e_cur = q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL pending_event at=%0d got=none want=%b", e_cur.at, e_cur.v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
